// File: rtl/cp0_int_unit.sv
// Minimal CP0 interrupt/exception unit: STATUS/CAUSE/EPC registers, edge-detected
// interrupt pending bits and a RUN/TRAP/HANDLER/RET sequencer with no nesting.
module cp0_int_unit #(
   parameter int unsigned IRQ_CH   = 4,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mtc0,
   input  logic              mfc0,
   input  logic              eret,
   input  logic              syscall,
   input  logic [4:0]        cpr_sel,
   input  logic [31:0]       wdata,
   input  logic [31:0]       pc_cur,
   input  logic [IRQ_CH-1:0] irq_in,
   output logic [31:0]       rdata,
   output logic              trap,
   output logic              trap_ret,
   output logic [31:0]       trap_pc,
   output logic              in_handler
);

   typedef enum logic [1:0] {StRun, StTrap, StHandler, StRet} state_e;

   state_e            state_q;
   logic              ie_q, saved_ie_q;
   logic [IRQ_CH-1:0] mask_q, pend_q, irq_prev_q;
   logic [4:0]        exc_q;
   logic [31:0]       epc_q;
   logic              trap_q, trap_ret_q;

   logic              wr_status, wr_cause, wr_epc;
   logic [IRQ_CH-1:0] irq_rise, pend_clr, pend_d;
   logic              take;

   // Reads are purely combinational on cpr_sel; mfc0 carries no extra meaning here.
   logic unused_mfc0;
   assign unused_mfc0 = mfc0;

   assign wr_status = mtc0 && (cpr_sel == 5'd12);
   assign wr_cause  = mtc0 && (cpr_sel == 5'd13);
   assign wr_epc    = mtc0 && (cpr_sel == 5'd14);

   assign irq_rise = irq_in & ~irq_prev_q;
   assign pend_clr = wr_cause ? wdata[8 +: IRQ_CH] : '0;
   // New edges win over a same-cycle write-1-to-clear.
   assign pend_d   = (pend_q & ~pend_clr) | irq_rise;
   assign take     = (state_q == StRun) && (syscall || (ie_q && |(pend_q & mask_q)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StRun;
         ie_q       <= 1'b0;
         saved_ie_q <= 1'b0;
         mask_q     <= '0;
         pend_q     <= '0;
         irq_prev_q <= '0;
         exc_q      <= '0;
         epc_q      <= '0;
         trap_q     <= 1'b0;
         trap_ret_q <= 1'b0;
      end else begin
         irq_prev_q <= irq_in;
         pend_q     <= pend_d;
         trap_q     <= 1'b0;
         trap_ret_q <= 1'b0;
         if (wr_status) begin
            ie_q   <= wdata[0];
            mask_q <= wdata[8 +: IRQ_CH];
         end
         if (wr_epc) begin
            epc_q <= wdata;
         end
         // Later assignments below override the mtc0 writes above.
         case (state_q)
            StRun: begin
               if (take) begin
                  state_q    <= StTrap;
                  trap_q     <= 1'b1;
                  saved_ie_q <= ie_q;
                  ie_q       <= 1'b0;
                  if (syscall) begin
                     epc_q <= pc_cur + 32'd4;
                     exc_q <= 5'd8;
                  end else begin
                     epc_q <= pc_cur;
                     exc_q <= 5'd0;
                  end
               end
            end
            StTrap: state_q <= StHandler;
            StHandler: begin
               if (eret) begin
                  ie_q       <= saved_ie_q;
                  state_q    <= StRet;
                  trap_ret_q <= 1'b1;
               end
            end
            StRet: state_q <= StRun;
            default: state_q <= StRun;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (cpr_sel)
         5'd12: begin
            rdata[0]            = ie_q;
            rdata[8 +: IRQ_CH]  = mask_q;
         end
         5'd13: begin
            rdata[8 +: IRQ_CH]  = pend_q;
            rdata[6:2]          = exc_q;
         end
         5'd14: rdata = epc_q;
         default: rdata = '0;
      endcase
   end

   assign trap       = trap_q;
   assign trap_ret   = trap_ret_q;
   assign trap_pc    = (trap_ret_q && rst_n) ? epc_q : TRAP_VEC;
   assign in_handler = (state_q == StHandler);

endmodule

// File: tb/tb_cp0_int_unit.sv
// Directed bench for cp0_int_unit (IRQ_CH=4, TRAP_VEC=32'h800).
module tb_cp0_int_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mtc0, mfc0, eret, syscall;
   logic [4:0]  cpr_sel;
   logic [31:0] wdata, pc_cur;
   logic [3:0]  irq_in;
   logic [31:0] rdata;
   logic        trap, trap_ret;
   logic [31:0] trap_pc;
   logic        in_handler;

   int checks   = 0;
   int failures = 0;
   logic [31:0] v;

   cp0_int_unit #(.IRQ_CH(4), .TRAP_VEC(32'h0000_0800)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mtc0       (mtc0),
      .mfc0       (mfc0),
      .eret       (eret),
      .syscall    (syscall),
      .cpr_sel    (cpr_sel),
      .wdata      (wdata),
      .pc_cur     (pc_cur),
      .irq_in     (irq_in),
      .rdata      (rdata),
      .trap       (trap),
      .trap_ret   (trap_ret),
      .trap_pc    (trap_pc),
      .in_handler (in_handler)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] sel, output logic [31:0] val);
      cpr_sel = sel;
      mfc0    = 1'b1;
      #1;
      val  = rdata;
      mfc0 = 1'b0;
   endtask

   task automatic wr(input logic [4:0] sel, input logic [31:0] d);
      mtc0    = 1'b1;
      cpr_sel = sel;
      wdata   = d;
      tick();
      mtc0 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL rst_trap got=%b exp=0", trap); end
      checks++; if (trap_ret !== 1'b0) begin failures++; $display("FAIL rst_trap_ret got=%b exp=0", trap_ret); end
      checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL rst_in_handler got=%b exp=0", in_handler); end
      checks++; if (trap_pc !== 32'h800) begin failures++; $display("FAIL rst_trap_pc got=%h exp=00000800", trap_pc); end
      rd(5'd12, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", v); end
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_cause got=%h exp=0", v); end
      rd(5'd14, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_epc got=%h exp=0", v); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mtc0_read();
      wr(5'd12, 32'h0000_0301);
      rd(5'd12, v);
      checks++; if (v !== 32'h0000_0301) begin failures++; $display("FAIL status_rw got=%h exp=00000301", v); end
      rd(5'd5, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_sel got=%h exp=0", v); end
      wr(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, v);
      checks++; if (v !== 32'h0000_0F01) begin failures++; $display("FAIL status_unimpl got=%h exp=00000f01", v); end
      wr(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL cause_ro got=%h exp=0", v); end
      wr(5'd14, 32'h1234_5678);
      rd(5'd14, v);
      checks++; if (v !== 32'h1234_5678) begin failures++; $display("FAIL epc_rw got=%h exp=12345678", v); end
      wr(5'd12, 32'h0000_0201);
   endtask

   task automatic test_irq_trap();
      pc_cur = 32'h100;
      irq_in = 4'b0010;
      tick();
      rd(5'd13, v);
      checks++; if (v !== 32'h200) begin failures++; $display("FAIL irq_pend got=%h exp=00000200", v); end
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL irq_early_trap got=%b exp=0", trap); end
      tick();
      checks++; if (trap !== 1'b1) begin failures++; $display("FAIL irq_trap got=%b exp=1", trap); end
      checks++; if (trap_pc !== 32'h800) begin failures++; $display("FAIL irq_trap_pc got=%h exp=00000800", trap_pc); end
      rd(5'd14, v);
      checks++; if (v !== 32'h100) begin failures++; $display("FAIL irq_epc got=%h exp=00000100", v); end
      rd(5'd12, v);
      checks++; if (v !== 32'h200) begin failures++; $display("FAIL irq_ie_clr got=%h exp=00000200", v); end
      tick();
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL irq_trap_width got=%b exp=0", trap); end
      checks++; if (in_handler !== 1'b1) begin failures++; $display("FAIL irq_in_handler got=%b exp=1", in_handler); end
   endtask

   task automatic test_eret();
      wr(5'd13, 32'h200);
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL w1c_pend got=%h exp=0", v); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      checks++; if (trap_ret !== 1'b1) begin failures++; $display("FAIL eret_pulse got=%b exp=1", trap_ret); end
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL eret_no_trap got=%b exp=0", trap); end
      checks++; if (trap_pc !== 32'h100) begin failures++; $display("FAIL eret_pc got=%h exp=00000100", trap_pc); end
      checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL eret_in_handler got=%b exp=0", in_handler); end
      rd(5'd12, v);
      checks++; if (v !== 32'h201) begin failures++; $display("FAIL eret_ie got=%h exp=00000201", v); end
      tick();
      checks++; if (trap_ret !== 1'b0) begin failures++; $display("FAIL eret_width got=%b exp=0", trap_ret); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      checks++; if (trap_ret !== 1'b0) begin failures++; $display("FAIL eret_in_run got=%b exp=0", trap_ret); end
   endtask

   task automatic test_syscall_priority();
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0010;
      tick();
      syscall = 1'b1;
      pc_cur  = 32'h40;
      tick();
      syscall = 1'b0;
      pc_cur  = 32'h80;
      checks++; if (trap !== 1'b1) begin failures++; $display("FAIL sys_trap got=%b exp=1", trap); end
      rd(5'd14, v);
      checks++; if (v !== 32'h44) begin failures++; $display("FAIL sys_epc got=%h exp=00000044", v); end
      rd(5'd13, v);
      checks++; if (v !== 32'h220) begin failures++; $display("FAIL sys_cause got=%h exp=00000220", v); end
      tick();
      syscall = 1'b1;
      tick();
      syscall = 1'b0;
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL sys_nested got=%b exp=0", trap); end
      checks++; if (in_handler !== 1'b1) begin failures++; $display("FAIL sys_in_handler got=%b exp=1", in_handler); end
      rd(5'd14, v);
      checks++; if (v !== 32'h44) begin failures++; $display("FAIL sys_epc_kept got=%h exp=00000044", v); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      checks++; if (trap_pc !== 32'h44 || trap_ret !== 1'b1) begin
         failures++; $display("FAIL sys_ret got=%h/%b exp=00000044/1", trap_pc, trap_ret);
      end
      tick();
      checks++; if (trap !== 1'b0 || trap_ret !== 1'b0) begin
         failures++; $display("FAIL ret_run_gap got=%b/%b exp=0/0", trap, trap_ret);
      end
      tick();
      checks++; if (trap !== 1'b1) begin failures++; $display("FAIL pend_after_ret got=%b exp=1", trap); end
      rd(5'd14, v);
      checks++; if (v !== 32'h80) begin failures++; $display("FAIL irq2_epc got=%h exp=00000080", v); end
      rd(5'd13, v);
      checks++; if (v !== 32'h200) begin failures++; $display("FAIL irq2_cause got=%h exp=00000200", v); end
      tick();
   endtask

   task automatic test_reset_in_handler();
      checks++; if (in_handler !== 1'b1) begin failures++; $display("FAIL pre_rst_handler got=%b exp=1", in_handler); end
      rst_n  = 1'b0;
      irq_in = 4'b0000;
      tick();
      checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL hrst_in_handler got=%b exp=0", in_handler); end
      checks++; if (trap_ret !== 1'b0 || trap !== 1'b0) begin
         failures++; $display("FAIL hrst_pulses got=%b/%b exp=0/0", trap, trap_ret);
      end
      checks++; if (trap_pc !== 32'h800) begin failures++; $display("FAIL hrst_trap_pc got=%h exp=00000800", trap_pc); end
      rd(5'd12, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL hrst_status got=%h exp=0", v); end
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL hrst_cause got=%h exp=0", v); end
      rd(5'd14, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL hrst_epc got=%h exp=0", v); end
      rst_n = 1'b1;
      tick();
      checks++; if (trap_ret !== 1'b0 || trap !== 1'b0) begin
         failures++; $display("FAIL hrst_after got=%b/%b exp=0/0", trap, trap_ret);
      end
   endtask

   task automatic test_ie_gate();
      wr(5'd12, 32'h100);
      irq_in = 4'b0001;
      tick();
      rd(5'd13, v);
      checks++; if (v !== 32'h100) begin failures++; $display("FAIL gate_pend got=%h exp=00000100", v); end
      tick();
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL gate_masked got=%b exp=0", trap); end
      wr(5'd12, 32'h101);
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL gate_write_cycle got=%b exp=0", trap); end
      tick();
      checks++; if (trap !== 1'b1) begin failures++; $display("FAIL gate_trap got=%b exp=1", trap); end
      rd(5'd12, v);
      checks++; if (v !== 32'h100) begin failures++; $display("FAIL gate_ie_clr got=%h exp=00000100", v); end
      tick();
   endtask

   task automatic test_pend_precedence();
      irq_in = 4'b0000;
      wr(5'd13, 32'h100);
      rd(5'd13, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL prec_clr got=%h exp=0", v); end
      irq_in = 4'b0001;
      wr(5'd13, 32'h100);
      rd(5'd13, v);
      checks++; if (v !== 32'h100) begin failures++; $display("FAIL prec_set_wins got=%h exp=00000100", v); end
   endtask

   task automatic test_eret_mtc0();
      eret    = 1'b1;
      mtc0    = 1'b1;
      cpr_sel = 5'd12;
      wdata   = 32'h0000_0F00;
      tick();
      eret = 1'b0;
      mtc0 = 1'b0;
      checks++; if (trap_ret !== 1'b1) begin failures++; $display("FAIL em_ret got=%b exp=1", trap_ret); end
      rd(5'd12, v);
      checks++; if (v !== 32'h0F01) begin failures++; $display("FAIL em_status got=%h exp=00000f01", v); end
      tick();
      checks++; if (trap !== 1'b0) begin failures++; $display("FAIL em_run_gap got=%b exp=0", trap); end
      tick();
      checks++; if (trap !== 1'b1 || trap_ret !== 1'b0) begin
         failures++; $display("FAIL em_retrap got=%b/%b exp=1/0", trap, trap_ret);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      mtc0    = 1'b0;
      mfc0    = 1'b0;
      eret    = 1'b0;
      syscall = 1'b0;
      cpr_sel = 5'd0;
      wdata   = 32'h0;
      pc_cur  = 32'h0;
      irq_in  = 4'b0000;
      test_reset();
      test_mtc0_read();
      test_irq_trap();
      test_eret();
      test_syscall_priority();
      test_reset_in_handler();
      test_ie_gate();
      test_pend_precedence();
      test_eret_mtc0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
